// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel/window constants and window slice indexing
package img_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int WIN_N      = 9;
   localparam int WIN_CENTER = 4;

   // Bit offset of window slice (row, col); row 0 = top, col 0 = left.
   function automatic int win_base(input int row, input int col, input int dw);
      return (row * 3 + col) * dw;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-line pixel store, sync write, combinational read
// Reading the address being written returns the old contents (read-before-write).
module line_buffer #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - streaming 3x3 window generator feeding the median stage
// Optional WIN_CNT_EN adds a 32-bit count of transferred windows on win_count.
module window_gen_3x3
   import img_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_pixel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIN_N*DATA_W-1:0] out_window,
   output logic                    out_last
`ifdef WIN_CNT_EN
   ,
   output logic [31:0]             win_count
`endif
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(2);
   localparam logic [RW-1:0] ROW_MIN  = RW'(2);

   logic [CW-1:0]             r_col;
   logic [RW-1:0]             r_row;
   logic [DATA_W-1:0]         r_arr [WIN_N];
   logic                      r_out_valid;
   logic                      r_out_last;
   logic [WIN_N*DATA_W-1:0]   r_out_window;

   logic [DATA_W-1:0]         w_arr_next [WIN_N];
   logic [WIN_N*DATA_W-1:0]   w_win_packed;
   logic [DATA_W-1:0]         w_lb0_rd;
   logic [DATA_W-1:0]         w_lb1_rd;
   logic                      w_in_fire;
   logic                      w_out_fire;
   logic                      w_emit;
   logic                      w_last;
   logic                      w_col_wrap;

   assign in_ready   = !r_out_valid || out_ready;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_out_valid && out_ready;
   assign w_col_wrap = (r_col == COL_LAST);
   assign w_emit     = w_in_fire && (r_row >= ROW_MIN) && (r_col >= COL_MIN);
   assign w_last     = (r_row == ROW_LAST) && w_col_wrap;

   // lb1 holds the line two above the current one, lb0 the line directly above.
   line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
      .clk     (clk),
      .i_we    (w_in_fire),
      .i_addr  (r_col),
      .i_wdata (in_pixel),
      .o_rdata (w_lb0_rd)
   );

   line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
      .clk     (clk),
      .i_we    (w_in_fire),
      .i_addr  (r_col),
      .i_wdata (w_lb0_rd),
      .o_rdata (w_lb1_rd)
   );

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         w_arr_next[r*3 + 0] = r_arr[r*3 + 1];
         w_arr_next[r*3 + 1] = r_arr[r*3 + 2];
      end
      w_arr_next[2] = w_lb1_rd;
      w_arr_next[5] = w_lb0_rd;
      w_arr_next[8] = in_pixel;
   end

   always_comb begin
      w_win_packed = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w_win_packed[win_base(r, c, DATA_W) +: DATA_W] = w_arr_next[r*3 + c];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_in_fire) begin
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < WIN_N; k++) begin
            r_arr[k] <= '0;
         end
      end else if (w_in_fire) begin
         for (int k = 0; k < WIN_N; k++) begin
            r_arr[k] <= w_arr_next[k];
         end
      end
   end

   // Single output register: a new window may load in the same cycle the old one leaves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_window <= '0;
      end else if (w_emit) begin
         r_out_valid  <= 1'b1;
         r_out_last   <= w_last;
         r_out_window <= w_win_packed;
      end else if (w_out_fire) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_last   = r_out_last;
   assign out_window = r_out_window;

`ifdef WIN_CNT_EN
   logic [31:0] r_win_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_count <= '0;
      end else if (w_out_fire) begin
         r_win_count <= r_win_count + 32'd1;
      end
   end

   assign win_count = r_win_count;
`endif

endmodule
